// File: rtl/rank_filter3x3_if.sv
// rank_filter3x3_if: pixel stream bundle (sync, strobe, data, mode in; delayed sync and filtered data out)
interface rank_filter3x3_if #(parameter int DATA_W = 8);
    logic              per_frame_vsync;
    logic              per_frame_href;
    logic              per_frame_clken;
    logic [DATA_W-1:0] per_data;
    logic [1:0]        mode;
    logic              post_frame_vsync;
    logic              post_frame_href;
    logic              post_frame_clken;
    logic [DATA_W-1:0] post_data;
    modport master (
        output per_frame_vsync, per_frame_href, per_frame_clken, per_data, mode,
        input  post_frame_vsync, post_frame_href, post_frame_clken, post_data
    );
    modport slave (
        input  per_frame_vsync, per_frame_href, per_frame_clken, per_data, mode,
        output post_frame_vsync, post_frame_href, post_frame_clken, post_data
    );
endinterface

// File: rtl/rank_filter3x3.sv
// rank_filter3x3: 3x3 median/min/max/bypass rank filter with built-in line buffers, fixed 4-clk latency
module rank_filter3x3 #(
    parameter int DATA_W      = 8,
    parameter int IMG_HDISP   = 320,
    parameter int BORDER_MODE = 0
) (
    input logic             clk,
    input logic             rst_n,
    rank_filter3x3_if.slave bus
);
    localparam int AW = $clog2(IMG_HDISP);
    localparam int CW = $clog2(IMG_HDISP + 1);
    localparam logic [CW-1:0] HMAX = CW'(IMG_HDISP);
    typedef logic [DATA_W-1:0] px_t;

    function automatic px_t max2(input px_t a, input px_t b);
        return a >= b ? a : b;
    endfunction
    function automatic px_t min2(input px_t a, input px_t b);
        return a >= b ? b : a;
    endfunction
    function automatic px_t max3(input px_t a, input px_t b, input px_t c);
        return max2(max2(a, b), c);
    endfunction
    function automatic px_t min3(input px_t a, input px_t b, input px_t c);
        return min2(min2(a, b), c);
    endfunction
    function automatic px_t med3(input px_t a, input px_t b, input px_t c);
        return max2(min2(a, b), min2(max2(a, b), c));
    endfunction

    logic          accept, href_fall, in_range, win_valid;
    logic          href_d, vsync_d;
    logic [CW-1:0] col;
    logic [AW-1:0] col_idx;
    logic [1:0]    row;
    px_t           buf1 [IMG_HDISP];
    px_t           buf2 [IMG_HDISP];
    px_t           tap1, tap2;
    px_t           win [3][3];
    logic          s1_valid, s2_valid, s3_valid;
    logic [1:0]    s1_mode, s2_mode, s3_mode;
    px_t           s1_pix, s2_pix, s3_pix;
    px_t           s2_hi [3];
    px_t           s2_md [3];
    px_t           s2_lo [3];
    px_t           s3_max_min, s3_mid_mid, s3_min_max, s3_min, s3_max;
    px_t           sel, result, out_q;
    logic [3:0]    vs_d, hr_d, ac_d;

    always_comb begin
        accept    = bus.per_frame_href && bus.per_frame_clken;
        href_fall = href_d && !bus.per_frame_href;
        in_range  = col < HMAX;
        win_valid = row[1] && col >= CW'(2) && in_range;
        col_idx   = col[AW-1:0];
        tap1      = buf1[col_idx];
        tap2      = buf2[col_idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            href_d  <= 1'b0;
            vsync_d <= 1'b0;
            col     <= '0;
            row     <= '0;
        end else begin
            href_d  <= bus.per_frame_href;
            vsync_d <= bus.per_frame_vsync;
            if (href_fall)
                col <= '0;
            else if (accept && in_range)
                col <= col + CW'(1);
            if (bus.per_frame_vsync && !vsync_d)
                row <= '0;
            else if (href_fall && !row[1])
                row <= row + 2'd1;
        end
    end

    // read-before-write cascade: buf2 receives the line buf1 held before this pixel
    always_ff @(posedge clk) begin
        if (accept && in_range) begin
            buf1[col_idx] <= bus.per_data;
            buf2[col_idx] <= buf1[col_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    win[i][j] <= '0;
            s1_valid <= 1'b0;
            s1_mode  <= '0;
            s1_pix   <= '0;
        end else if (accept) begin
            for (int i = 0; i < 3; i++) begin
                win[i][0] <= win[i][1];
                win[i][1] <= win[i][2];
            end
            win[0][2] <= tap2;
            win[1][2] <= tap1;
            win[2][2] <= bus.per_data;
            s1_valid  <= win_valid;
            s1_mode   <= bus.mode;
            s1_pix    <= in_range ? bus.per_data : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                s2_hi[i] <= '0;
                s2_md[i] <= '0;
                s2_lo[i] <= '0;
            end
            {s2_valid, s2_mode, s2_pix} <= '0;
            {s3_valid, s3_mode, s3_pix} <= '0;
            {s3_max_min, s3_mid_mid, s3_min_max, s3_min, s3_max} <= '0;
            out_q <= '0;
            vs_d  <= '0;
            hr_d  <= '0;
            ac_d  <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                s2_hi[i] <= max3(win[i][0], win[i][1], win[i][2]);
                s2_md[i] <= med3(win[i][0], win[i][1], win[i][2]);
                s2_lo[i] <= min3(win[i][0], win[i][1], win[i][2]);
            end
            {s2_valid, s2_mode, s2_pix} <= {s1_valid, s1_mode, s1_pix};
            {s3_valid, s3_mode, s3_pix} <= {s2_valid, s2_mode, s2_pix};
            s3_max_min <= min3(s2_hi[0], s2_hi[1], s2_hi[2]);
            s3_mid_mid <= med3(s2_md[0], s2_md[1], s2_md[2]);
            s3_min_max <= max3(s2_lo[0], s2_lo[1], s2_lo[2]);
            s3_min     <= min3(s2_lo[0], s2_lo[1], s2_lo[2]);
            s3_max     <= max3(s2_hi[0], s2_hi[1], s2_hi[2]);
            if (ac_d[2])
                out_q <= result;
            vs_d <= {vs_d[2:0], bus.per_frame_vsync};
            hr_d <= {hr_d[2:0], bus.per_frame_href};
            ac_d <= {ac_d[2:0], accept};
        end
    end

    always_comb begin
        sel = s3_mode == 2'b00 ? med3(s3_max_min, s3_mid_mid, s3_min_max) :
              s3_mode == 2'b01 ? s3_min :
              s3_mode == 2'b10 ? s3_max : s3_pix;
        result = s3_valid ? sel : (BORDER_MODE != 0 ? s3_pix : '0);
    end

    assign bus.post_frame_vsync = vs_d[3];
    assign bus.post_frame_href  = hr_d[3];
    assign bus.post_frame_clken = ac_d[3];
    assign bus.post_data        = out_q;
endmodule

// File: tb/tb_rank_filter3x3.sv
// tb_rank_filter3x3: three filter instances (8-bit zero border, 8-bit pixel border, 12-bit) against a sorting reference model
module tb_rank_filter3x3;
    logic        clk = 1'b0, rst_n = 1'b1, vsync = 1'b0, href = 1'b0, clken = 1'b0;
    logic [7:0]  d8 = '0;
    logic [11:0] d12 = '0;
    logic [1:0]  mode = '0;
    int checks = 0, errors = 0, cyc = 0, mrow = 0, mcol = 0, v = 0;
    int img8 [16][12];
    int img12 [16][12];
    int wv [9] = '{4095, 0, 2048, 1, 4094, 2, 3, 4093, 2047};
    int wexp [3] = '{2047, 0, 4095};
    int mds [3] = '{0, 2, 1};
    typedef struct { logic [7:0] e0, e1; logic [11:0] e2; int stamp, tag; } exp_t;
    exp_t q[$];
    exp_t me;
    logic [3:0]  vh, hh, ah;
    logic [7:0]  last0;
    logic [11:0] wide_res [3];

    always #5 clk = ~clk;

    rank_filter3x3_if #(.DATA_W(8))  b0 ();
    rank_filter3x3_if #(.DATA_W(8))  b1 ();
    rank_filter3x3_if #(.DATA_W(12)) b2 ();
    assign {b0.per_frame_vsync, b0.per_frame_href, b0.per_frame_clken, b0.per_data, b0.mode} = {vsync, href, clken, d8, mode};
    assign {b1.per_frame_vsync, b1.per_frame_href, b1.per_frame_clken, b1.per_data, b1.mode} = {vsync, href, clken, d8, mode};
    assign {b2.per_frame_vsync, b2.per_frame_href, b2.per_frame_clken, b2.per_data, b2.mode} = {vsync, href, clken, d12, mode};

    rank_filter3x3 #(.DATA_W(8),  .IMG_HDISP(8), .BORDER_MODE(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
    rank_filter3x3 #(.DATA_W(8),  .IMG_HDISP(8), .BORDER_MODE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
    rank_filter3x3 #(.DATA_W(12), .IMG_HDISP(8), .BORDER_MODE(0)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_px(input int r, input int c, input logic [1:0] md, input bit bm, input bit wide);
        int w[9];
        int t, p;
        p = wide ? img12[r][c] : img8[r][c];
        if (c >= 8) return 0;
        if (r < 2 || c < 2) return bm ? p : 0;
        if (md == 2'b11) return p;
        for (int i = 0; i < 9; i++)
            w[i] = wide ? img12[r-2+i/3][c-2+i%3] : img8[r-2+i/3][c-2+i%3];
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8 - i; j++)
                if (w[j] > w[j+1]) begin
                    t = w[j]; w[j] = w[j+1]; w[j+1] = t;
                end
        return md == 2'b00 ? w[4] : md == 2'b01 ? w[0] : w[8];
    endfunction

    task automatic px(input int p8, input int p12, input logic [1:0] md, input bit acc, input int tag);
        exp_t e;
        @(posedge clk); #1;
        href = 1'b1; clken = acc; mode = md; d8 = 8'(p8); d12 = 12'(p12);
        if (acc) begin
            img8[mrow][mcol]  = p8;
            img12[mrow][mcol] = p12;
            e.e0    = 8'(exp_px(mrow, mcol, md, 1'b0, 1'b0));
            e.e1    = 8'(exp_px(mrow, mcol, md, 1'b1, 1'b0));
            e.e2    = 12'(exp_px(mrow, mcol, md, 1'b0, 1'b1));
            e.stamp = cyc;
            e.tag   = tag;
            q.push_back(e);
            mcol++;
        end
    endtask

    task automatic end_line();
        @(posedge clk); #1;
        href = 1'b0; clken = 1'b0;
        mrow++; mcol = 0;
        repeat (2) @(posedge clk);
    endtask

    task automatic frame_start();
        @(posedge clk); #1;
        href = 1'b0; clken = 1'b0; vsync = 1'b1;
        @(posedge clk); #1;
        vsync = 1'b0; mrow = 0; mcol = 0;
        repeat (2) @(posedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        chk("drain", q.size(), 0);
    endtask

    task automatic rst_chk();
        chk("rst_vsync", b0.post_frame_vsync, 0);
        chk("rst_href", b0.post_frame_href, 0);
        chk("rst_clken", b0.post_frame_clken, 0);
        chk("rst_data0", b0.post_data, 0);
        chk("rst_data1", b1.post_data, 0);
        chk("rst_data2", b2.post_data, 0);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vh <= '0; hh <= '0; ah <= '0;
        end else begin
            vh <= {vh[2:0], vsync};
            hh <= {hh[2:0], href};
            ah <= {ah[2:0], href && clken};
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            last0 = '0;
        end else begin
            chk("vsync_delay", b0.post_frame_vsync, vh[3]);
            chk("href_delay", b0.post_frame_href, hh[3]);
            chk("clken_delay", b0.post_frame_clken, ah[3]);
            chk("clken_dut1", b1.post_frame_clken, ah[3]);
            chk("clken_dut2", b2.post_frame_clken, ah[3]);
            if (b0.post_frame_clken) begin
                chk("queue_nonempty", q.size() != 0, 1);
                if (q.size() != 0) begin
                    me = q.pop_front();
                    chk("latency", cyc, me.stamp + 4);
                    chk("data_dut0", b0.post_data, me.e0);
                    chk("data_dut1", b1.post_data, me.e1);
                    chk("data_dut2", b2.post_data, me.e2);
                    if (me.tag != 0) wide_res[me.tag-1] = b2.post_data;
                end
                last0 = b0.post_data;
            end else begin
                chk("hold", b0.post_data, last0);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_chk();
        rst_n = 1'b1;
        // impulse image: median, then max, then min
        for (int m = 0; m < 3; m++) begin
            frame_start();
            for (int r = 0; r < 6; r++) begin
                for (int c = 0; c < 8; c++) begin
                    v = (r == 3 && c == 4) ? 255 : 50;
                    px(v, v * 16, 2'(mds[m]), 1'b1, 0);
                end
                end_line();
            end
            drain();
        end
        // sparse ramp with garbage in the gaps, median switching to bypass at col 5
        frame_start();
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 8; c++) begin
                px(c * 10, c * 160, c < 5 ? 2'b00 : 2'b11, 1'b1, 0);
                px(238, 3822, 2'b10, 1'b0, 0);
                px(238, 3822, 2'b10, 1'b0, 0);
            end
            end_line();
        end
        drain();
        // overlong line 3, next line must be unaffected
        frame_start();
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < (r == 3 ? 10 : 8); c++) begin
                v = (r * 37 + c * 11) % 256;
                px(v, v * 16 + r, 2'b00, 1'b1, 0);
            end
            end_line();
        end
        drain();
        // wide data window at output (2,2)
        for (int m = 0; m < 3; m++) begin
            wide_res[m] = 12'hABC;
            frame_start();
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 8; c++) begin
                    v = c < 3 ? wv[r*3+c] : 100 + c * r;
                    px(v / 16, v, 2'(m), 1'b1, (r == 2 && c == 2) ? m + 1 : 0);
                end
                end_line();
            end
            drain();
            chk("wide_result", wide_res[m], wexp[m]);
        end
        // reset in the middle of a line
        frame_start();
        for (int c = 0; c < 8; c++) px(c + 1, c + 1, 2'b00, 1'b1, 0);
        end_line();
        for (int c = 0; c < 4; c++) px(100 + c, 100 + c, 2'b00, 1'b1, 0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1 rst_chk();
        q.delete();
        href = 1'b0; clken = 1'b0; mrow = 0; mcol = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 8; c++) px(r * 30 + c * 3, r * 30 + c * 3, 2'b00, 1'b1, 0);
            end_line();
        end
        drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rank_filter3x3.md
Name: rank_filter3x3

Overview:
- Parametrised 3x3 rank-order filter for the Image_Process/Filter chain. It is the next generation of the fixed 8-bit median block.
- Generic data width and line length, with built-in line buffers (no external matrix generator).
- Per-pixel runtime mode: median, erode (min), dilate (max), bypass.
- Explicit border handling and a fixed, documented latency on data and sync signals alike.

Parameters:
- DATA_W, 8: pixel width in bits.
- IMG_HDISP, 320: active pixels per line; this is the line-buffer depth.
- BORDER_MODE, 0: 0 = output zero where the window is incomplete; 1 = output the newest input pixel there.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  reset; asynchronous, active-low
- per_frame_vsync  in  1  input frame sync, active high
- per_frame_href  in  1  input line valid
- per_frame_clken  in  1  input pixel strobe; a pixel is accepted when href && clken
- per_data  in  DATA_W  input pixel
- mode  in  2  00 median, 01 min, 10 max, 11 bypass; sampled with each accepted pixel
- post_frame_vsync  out  1  vsync delayed 4 clk
- post_frame_href  out  1  href delayed 4 clk
- post_frame_clken  out  1  accept strobe (href && clken) delayed 4 clk
- post_data  out  DATA_W  filtered pixel, valid when post_frame_clken = 1

Behaviour:
- Reset: all outputs, pipeline registers, counters and sync delay lines go to 0 asynchronously. Line-buffer RAM contents are not reset; border masking makes stale data unobservable. Reset mid-frame: row counting restarts at 0, so the next two received lines are border lines.
- Column counter col:
  - increments on each accepted pixel;
  - clears to 0 on the clk after href falls.
  - Pixels with col >= IMG_HDISP are not written to the line buffers and produce post_data = 0.
- Row counter row:
  - increments on each href falling edge, saturating at 2;
  - clears to 0 on a vsync rising edge.
- Line buffers: two cascaded, depth IMG_HDISP.
  - On accept: tap0 = per_data, tap1 = buf1[col], tap2 = buf2[col].
  - Writes in the same cycle: buf1[col] <= per_data, buf2[col] <= old buf1[col] (read-before-write).
- Window: 3 columns x 3 taps. It shifts only on accept; the newest column is (tap2, tap1, tap0). The window's bottom-right element is the current input pixel, so output position (r,c) is the window over input rows r-2..r and columns c-2..c.
- Window-valid flag = (row >= 2) && (col >= 2) && (col < IMG_HDISP), computed at accept. It is carried down the pipeline with mode and the bottom-right pixel.
- Pipeline: advances every clk, not gated by clken.
  - Stage 1 (window register): registered on accept.
  - Stage 2: sort each window row into max/mid/min.
  - Stage 3: compute the following, plus min-of-mins and max-of-maxes:
    - max_min = min of the row maxima;
    - mid_mid = median of the row mids;
    - min_max = max of the row minima.
  - Stage 4: final select.
    - Median = median(max_min, mid_mid, min_max).
    - Min = min-of-mins.
    - Max = max-of-maxes.
    - Bypass = bottom-right pixel.
    - If the window-valid flag is 0: output 0 (BORDER_MODE 0) or the bottom-right pixel (BORDER_MODE 1), whatever the mode.
- Latency: exactly 4 clk from an accepted input to its post_frame_clken and post_data. vsync and href take the same 4-clk shift.
- post_data holds its last value while post_frame_clken = 0.
- Comparisons are unsigned, ties by >=. Result is exact for all DATA_W with no widening; equal inputs give that value.
- Mode is pipelined per pixel: a change mid-line affects only pixels accepted after the change.
- Accepted pixels may be back-to-back (clken every clk) or sparse. Gaps do not shift the window.

Test Plan:
- Reset and flush: rst_n low mid-line → all outputs 0 immediately. After release, the first two full lines give post_data = 0 (BORDER_MODE 0) with post_frame_clken echoing input clken, 4 clk late.
- Median impulse: DATA_W=8, IMG_HDISP=8, flat image of 50 with a single 255 at row 3, col 4; continuous clken, mode 00 → every valid output = 50, no 255 anywhere; latency 4 clk.
- Min/max morphology: same image, mode 10 → 255 at output positions (r,c) with r in 3..5 and c in 4..6, else 50. Mode 01 → all 50.
- Sparse clken and mode switch: ramp pixel = col*10, clken every 3rd clk, mode toggles 00→11 at col 5 → identical results to continuous clken. Bypass outputs equal the input pixel (col*10) from col 5 on.
- Border mode and overlong line: BORDER_MODE=1 → rows 0–1 and cols 0–1 output the input pixel. With 10 pixels fed on a line of IMG_HDISP=8 → cols 8–9 output 0 and the next line is unaffected.
- Wide data: DATA_W=12, window {4095,0,2048,1,4094,2,3,4093,2047} → median 2047, min 0, max 4095.
